// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial pair transmitter.
package serial_pkg;

   // Transmitter control states: nothing in flight, or a word being serialised
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_shift_out.sv
// One load/shift register that presents the current bit of a word at its output end.
module serial_shift_out
   import serial_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_bit
);

   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] w_shifted;

   // Move the next bit toward the output end: left for MSB-first, right for LSB-first
   always_comb begin
      w_shifted = r_data;
      if (LSB_FIRST) begin
         w_shifted = {1'b0, r_data[WIDTH-1:1]};
      end else begin
         w_shifted = {r_data[WIDTH-2:0], 1'b0};
      end
   end

   // Load a whole word or advance by one bit; cleared asynchronously on reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_data;
      end else if (i_shift) begin
         r_data <= w_shifted;
      end else begin
         r_data <= r_data;
      end
   end

   assign o_bit = LSB_FIRST ? r_data[0] : r_data[WIDTH-1];

endmodule

// File: rtl/serial_pair_transmitter.sv
// Serialises (a, b) word pairs one bit pair per clock with first/last framing.
// A one-entry holding buffer lets the next word follow with no gap.
module serial_pair_transmitter
   import serial_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   output logic             ser_a,
   output logic             ser_b,
   output logic             out_first,
   output logic             out_last
);

   localparam int            CW      = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [CW-1:0]    r_bit_cnt;
   logic [WIDTH-1:0] r_hold_a;
   logic [WIDTH-1:0] r_hold_b;
   logic             r_hold_full;
   logic             r_ready_en;

   logic             w_accept;
   logic             w_last;
   logic             w_load;
   logic             w_load_from_hold;
   logic             w_shift;
   logic             w_hold_set;
   logic             w_hold_clr;
   logic [WIDTH-1:0] w_load_a;
   logic [WIDTH-1:0] w_load_b;
   logic             w_bit_a;
   logic             w_bit_b;
   logic             w_out_valid;

   // in_ready is a decode of registers only, so there is no combinational input-to-output path
   assign w_accept = in_valid & in_ready;
   assign w_last   = (r_state == ST_SHIFT) && (r_bit_cnt == '0);
   assign w_load_a = w_load_from_hold ? r_hold_a : in_a;
   assign w_load_b = w_load_from_hold ? r_hold_b : in_b;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: stay shifting while a word is in flight, held, or arriving on the last bit
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_SHIFT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (w_last && !r_hold_full && !w_accept) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_SHIFT;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath control: where the next word comes from and whether the holding buffer fills or drains
   always_comb begin
      w_load           = 1'b0;
      w_load_from_hold = 1'b0;
      w_shift          = 1'b0;
      w_hold_set       = 1'b0;
      w_hold_clr       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_load = 1'b1;
            end else begin
               w_load = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (w_last) begin
               if (r_hold_full) begin
                  w_load           = 1'b1;
                  w_load_from_hold = 1'b1;
                  w_hold_clr       = 1'b1;
               end else if (w_accept) begin
                  w_load = 1'b1;
               end else begin
                  w_load = 1'b0;
               end
            end else begin
               w_shift = 1'b1;
               if (w_accept) begin
                  w_hold_set = 1'b1;
               end else begin
                  w_hold_set = 1'b0;
               end
            end
         end
         default: begin
            w_load = 1'b0;
         end
      endcase
   end

   // FSM outputs: everything forced low while no word is being shifted
   always_comb begin
      w_out_valid = (r_state == ST_SHIFT);
      out_valid   = w_out_valid;
      ser_a       = w_out_valid & w_bit_a;
      ser_b       = w_out_valid & w_bit_b;
      out_first   = w_out_valid && (r_bit_cnt == CNT_MAX);
      out_last    = w_out_valid && (r_bit_cnt == '0);
      in_ready    = r_ready_en & ~r_hold_full;
   end

   // Bit counter: restarts at WIDTH-1 on every load and counts down to the last bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bit_cnt <= '0;
      end else if (w_load) begin
         r_bit_cnt <= CNT_MAX;
      end else if (w_shift) begin
         r_bit_cnt <= r_bit_cnt - 1'b1;
      end else begin
         r_bit_cnt <= r_bit_cnt;
      end
   end

   // Holding buffer: captures a word accepted mid-shift, drains into the shifters on the last bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold_a    <= '0;
         r_hold_b    <= '0;
         r_hold_full <= 1'b0;
      end else if (w_hold_set) begin
         r_hold_a    <= in_a;
         r_hold_b    <= in_b;
         r_hold_full <= 1'b1;
      end else if (w_hold_clr) begin
         r_hold_full <= 1'b0;
      end else begin
         r_hold_full <= r_hold_full;
      end
   end

   // Keep in_ready low until the first clock edge after reset release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ready_en <= 1'b0;
      end else begin
         r_ready_en <= 1'b1;
      end
   end

   serial_shift_out #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST)
   ) u_shift_a (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (w_load_a),
      .o_bit   (w_bit_a)
   );

   serial_shift_out #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST)
   ) u_shift_b (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (w_load_b),
      .o_bit   (w_bit_b)
   );

endmodule
